seg_scan: RTL
=============

Name: seg_scan

Overview:
- Downstream consumer of the eight-digit segment-pattern generator: takes eight parallel 8-bit active-low segment patterns and time-multiplexes them onto one shared segment bus with a one-hot active-low digit select, for boards with a multiplexed 8-digit display.
- Frame-coherent: all eight inputs are snapshotted once per scan frame, so a mid-frame pattern change never tears.
- Each digit slot starts with a blanking interval to suppress ghosting.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot; legal range SCAN_DIV >= 2.
- BLANK_CYC, 16: blanked cycles at the start of each slot; legal range 0 <= BLANK_CYC < SCAN_DIV; 0 disables blanking.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- i_en  input  1  scan enable; low forces display dark and holds the scanner at frame start.
- i_seg0..i_seg7  input  8 each  active-low segment pattern for digit 0..7; opaque, passed through unmodified.
- o_seg  output  8  active-low segment bus for the currently selected digit.
- o_an  output  8  active-low one-hot digit select; bit n low = digit n lit.
- o_digit  output  3  index of the digit slot the outputs currently reflect.
- o_frame  output  1  one-cycle pulse marking the first cycle of a new frame after a snapshot reload.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values (rst_n low, asynchronous):
  - cnt=0, idx=0, all eight snapshot registers=8'hFF.
  - o_seg=8'hFF, o_an=8'hFF, o_digit=0, o_frame=0.
- Slot counter cnt:
  - Width is clog2(SCAN_DIV). It counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1, cnt returns to 0 and idx increments. idx is a 3-bit counter and wraps 7->0 naturally.
- Frame wrap: on the edge where idx==7 and cnt==SCAN_DIV-1, all eight snapshot registers load i_seg0..i_seg7 together.
  - Inputs sampled at that edge are displayed for the whole following frame.
  - Inputs are ignored at all other edges while i_en=1.
- First frame after reset displays 8'hFF on all digits, i.e. dark. This is intended.
- Outputs are registered with a fixed 1-cycle lag. After each edge they reflect the (idx, cnt, snapshot) that held before that edge:
  - If prev cnt < BLANK_CYC: o_an=8'hFF, o_seg=8'hFF.
  - Otherwise: o_an = ~(8'b1 << prev idx), o_seg = snapshot[prev idx].
  - o_digit = prev idx in both cases, including during blanking.
- o_frame: high for exactly one cycle, the cycle immediately after a wrap-triggered snapshot load. Never asserted while i_en=0.
- i_en=0 (synchronous):
  - Every edge sets cnt=0, idx=0, snapshot=current inputs.
  - o_an=8'hFF, o_seg=8'hFF, o_digit=0, o_frame=0.
- i_en 0->1: scanning starts from idx=0, cnt=0 using the inputs captured on the last disabled edge. No o_frame pulse at this start.
- i_en 1->0 mid-slot: takes effect at the next edge; there is no completion of the slot.
- Invariant: at most one bit of o_an is low in any cycle. o_an and o_seg change on the same edge.
- rst_n asserted mid-frame: all state and outputs go to reset values immediately, without waiting for clk. After release, counting restarts from 0 on the first edge.
- Frame period is exactly 8*SCAN_DIV cycles. The lit time per digit is SCAN_DIV-BLANK_CYC cycles.

Test Plan:
1. Reset: SCAN_DIV=8, BLANK_CYC=2, rst_n=0, inputs random -> o_seg=FF, o_an=FF, o_digit=0, o_frame=0 without clock; first frame after release fully dark.
2. Normal scan (SCAN_DIV=8, BLANK_CYC=2, i_en=1): i_segN=8'h10+N held -> o_frame pulses every 64 cycles. In frame 2, each slot shows 2 cycles o_an=FF then 6 cycles o_an=~(1<<N), o_seg=8'h10+N, o_digit=N; sequence 0..7 then wraps to 0.
3. Tear-free update: change i_seg3 from 8'h33 to 8'hC3 while o_digit=1 -> digit 3 shows 8'h33 for the rest of that frame and 8'hC3 from the next frame. The o_frame pulse precedes the change.
4. Enable gating: drop i_en mid-slot of digit 5 -> next cycle dark, o_digit=0. Change inputs, raise i_en -> digit 0 lights after BLANK_CYC+1 edges showing the last inputs sampled while disabled; no o_frame until first wrap.
5. BLANK_CYC=0, SCAN_DIV=2 -> no dark cycles; o_an sequence FE,FE,FD,FD,...,7F,7F repeats every 16 cycles.
6. Async reset mid-frame at digit 6 lit -> outputs FF immediately, before the next clk edge; scanning restarts at digit 0 showing FF until the first wrap reload.

Source files
------------

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexes eight active-low segment patterns onto one
// shared segment bus with an active-low one-hot digit select. Patterns are
// snapshotted once per frame so a mid-frame input change never tears, and
// every digit slot begins with a short blanking interval against ghosting.
module seg_scan #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [7:0] i_seg0,
  input  logic [7:0] i_seg1,
  input  logic [7:0] i_seg2,
  input  logic [7:0] i_seg3,
  input  logic [7:0] i_seg4,
  input  logic [7:0] i_seg5,
  input  logic [7:0] i_seg6,
  input  logic [7:0] i_seg7,
  output logic [7:0] o_seg,
  output logic [7:0] o_an,
  output logic [2:0] o_digit,
  output logic       o_frame
);

  localparam int unsigned     CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    snap   [8];
  logic [7:0]    seg_in [8];
  logic          slot_end;
  logic          frame_wrap;
  logic          blank;

  // Gather the parallel pattern inputs into an indexable array.
  always_comb begin
    seg_in[0] = i_seg0;
    seg_in[1] = i_seg1;
    seg_in[2] = i_seg2;
    seg_in[3] = i_seg3;
    seg_in[4] = i_seg4;
    seg_in[5] = i_seg5;
    seg_in[6] = i_seg6;
    seg_in[7] = i_seg7;
  end

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_wrap = i_en && slot_end && (idx == 3'd7);

  // With no blanking the compare would be against zero and always false,
  // so the term is dropped entirely rather than left as a constant compare.
  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign blank = 1'b0;
    end else begin : g_blank
      assign blank = (cnt < CW'(BLANK_CYC));
    end
  endgenerate

  // Slot/digit counters and the frame snapshot; disabled keeps tracking inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      for (int unsigned i = 0; i < 8; i++) snap[i] <= '1;
    end else if (!i_en) begin
      cnt <= '0;
      idx <= '0;
      for (int unsigned i = 0; i < 8; i++) snap[i] <= seg_in[i];
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (frame_wrap) begin
        for (int unsigned i = 0; i < 8; i++) snap[i] <= seg_in[i];
      end
    end
  end

  // Registered outputs, one cycle behind the counter state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_seg   <= '1;
      o_an    <= '1;
      o_digit <= '0;
      o_frame <= 1'b0;
    end else if (!i_en) begin
      o_seg   <= '1;
      o_an    <= '1;
      o_digit <= '0;
      o_frame <= 1'b0;
    end else begin
      o_digit <= idx;
      o_frame <= frame_wrap;
      if (blank) begin
        o_seg <= '1;
        o_an  <= '1;
      end else begin
        o_seg <= snap[idx];
        o_an  <= ~(8'd1 << idx);
      end
    end
  end

endmodule
